// File: rtl/ctrl_pipe_gen.sv
// Control-path pipeline for the 5-stage RV32I core: carries the decoded control
// bundle D->E->M->W, resolves branches from ALU flags and sequences MUL/DIV stalls.
module ctrl_pipe_gen #(
    parameter int ALUCTRL_W   = 4,
    parameter int RESSRC_W    = 2,
    parameter int MDU_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWriteD,
    input  logic                 MemWriteD,
    input  logic                 JumpD,
    input  logic                 JalrD,
    input  logic                 BranchD,
    input  logic [2:0]           Funct3D,
    input  logic                 MulDivD,
    input  logic                 ALUSrcAD,
    input  logic [1:0]           ALUSrcBD,
    input  logic [RESSRC_W-1:0]  ResultSrcD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 NegE,
    input  logic                 OvfE,
    input  logic                 CarryE,
    output logic                 PCSrcE,
    output logic                 PCJalrE,
    output logic                 ALUSrcAE,
    output logic [1:0]           ALUSrcBE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ResultSrcE0,
    output logic                 MduStartE,
    output logic                 MduStallE,
    output logic                 MemWriteM,
    output logic                 RegWriteM,
    output logic                 RegWriteW,
    output logic [RESSRC_W-1:0]  ResultSrcW
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    typedef struct packed {
        logic                 reg_write;
        logic                 mem_write;
        logic                 jump;
        logic                 jalr;
        logic                 branch;
        logic [2:0]           funct3;
        logic                 muldiv;
        logic                 alu_src_a;
        logic [1:0]           alu_src_b;
        logic [RESSRC_W-1:0]  result_src;
        logic [ALUCTRL_W-1:0] alu_control;
    } ctrl_e_t;

    typedef struct packed {
        logic                reg_write;
        logic                mem_write;
        logic [RESSRC_W-1:0] result_src;
    } ctrl_m_t;

    typedef struct packed {
        logic                reg_write;
        logic [RESSRC_W-1:0] result_src;
    } ctrl_w_t;

    // Carry clear means rs1 < rs2 unsigned; N^V is the signed less-than.
    function automatic logic branch_cond(input logic [2:0] funct3, input logic zero,
                                         input logic neg, input logic ovf, input logic carry);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return ~zero;
            3'b100:  return neg ^ ovf;
            3'b101:  return ~(neg ^ ovf);
            3'b110:  return ~carry;
            3'b111:  return carry;
            default: return 1'b0;
        endcase
    endfunction

    ctrl_e_t    d_bundle_s, e_d, e_q;
    ctrl_m_t    m_d, m_q;
    ctrl_w_t    w_d, w_q;
    mdu_state_e state_d, state_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic       mdu_start_s, mdu_stall_s;

    // Gather the decoded D-stage fields into one bundle
    always_comb begin
        d_bundle_s             = '0;
        d_bundle_s.reg_write   = RegWriteD;
        d_bundle_s.mem_write   = MemWriteD;
        d_bundle_s.jump        = JumpD;
        d_bundle_s.jalr        = JalrD;
        d_bundle_s.branch      = BranchD;
        d_bundle_s.funct3      = Funct3D;
        d_bundle_s.muldiv      = MulDivD;
        d_bundle_s.alu_src_a   = ALUSrcAD;
        d_bundle_s.alu_src_b   = ALUSrcBD;
        d_bundle_s.result_src  = ResultSrcD;
        d_bundle_s.alu_control = ALUControlD;
    end

    assign mdu_stall_s = e_q.muldiv & (state_q != MDU_DONE);

    // MDU sequencer next state; a flush abandons any op in flight
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mdu_start_s = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (e_q.muldiv) begin
                    mdu_start_s = 1'b1;
                    count_d     = CNT_LOAD;
                    state_d     = (MDU_LATENCY == 1) ? MDU_DONE : MDU_BUSY;
                end else begin
                    state_d = MDU_IDLE;
                end
            end
            MDU_BUSY: begin
                if (count_q == CNT_ONE) begin
                    state_d = MDU_DONE;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
            MDU_DONE: state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
        if (FlushE) begin
            state_d = MDU_IDLE;
            count_d = '0;
        end else begin
            state_d = state_d;
        end
    end

    // Pipeline register next values: flush beats hold in E, stalls bubble M
    always_comb begin
        e_d = e_q;
        if (FlushE) begin
            e_d = '0;
        end else if (mdu_stall_s) begin
            e_d = e_q;
        end else begin
            e_d = d_bundle_s;
        end
        m_d = '0;
        if (mdu_stall_s) begin
            m_d = '0;
        end else begin
            m_d.reg_write  = e_q.reg_write;
            m_d.mem_write  = e_q.mem_write;
            m_d.result_src = e_q.result_src;
        end
        w_d.reg_write  = m_q.reg_write;
        w_d.result_src = m_q.result_src;
    end

    // State and pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            state_q <= MDU_IDLE;
            count_q <= '0;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign PCSrcE      = (e_q.branch & branch_cond(e_q.funct3, ZeroE, NegE, OvfE, CarryE)) | e_q.jump;
    assign PCJalrE     = e_q.jump & e_q.jalr;
    assign ALUSrcAE    = e_q.alu_src_a;
    assign ALUSrcBE    = e_q.alu_src_b;
    assign ALUControlE = e_q.alu_control;
    assign ResultSrcE0 = e_q.result_src[0];
    assign MduStartE   = mdu_start_s;
    assign MduStallE   = mdu_stall_s;
    assign MemWriteM   = m_q.mem_write;
    assign RegWriteM   = m_q.reg_write;
    assign RegWriteW   = w_q.reg_write;
    assign ResultSrcW  = w_q.result_src;

endmodule

// File: tb/tb_ctrl_pipe_gen.sv
// Randomised bench for ctrl_pipe_gen against a transaction-level model that
// tracks the op held in E, its remaining stall cycles, and the later stages.
module tb_ctrl_pipe_gen;

    localparam int ALUCTRL_W = 4;
    localparam int RESSRC_W  = 2;
    localparam int LAT       = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic RegWriteD, MemWriteD, JumpD, JalrD, BranchD, MulDivD, ALUSrcAD, FlushE;
    logic [2:0] Funct3D;
    logic [1:0] ALUSrcBD;
    logic [RESSRC_W-1:0] ResultSrcD;
    logic [ALUCTRL_W-1:0] ALUControlD;
    logic ZeroE, NegE, OvfE, CarryE;
    logic PCSrcE, PCJalrE, ALUSrcAE, ResultSrcE0, MduStartE, MduStallE;
    logic MemWriteM, RegWriteM, RegWriteW;
    logic [1:0] ALUSrcBE;
    logic [ALUCTRL_W-1:0] ALUControlE;
    logic [RESSRC_W-1:0] ResultSrcW;

    // E-stage operands; the ALU flags are derived from them
    logic [31:0] rs1, rs2;
    logic [32:0] diff;
    assign diff   = {1'b0, rs1} - {1'b0, rs2};
    assign ZeroE  = (diff[31:0] == 32'd0);
    assign NegE   = diff[31];
    assign OvfE   = (rs1[31] != rs2[31]) && (diff[31] != rs1[31]);
    assign CarryE = ~diff[32];

    ctrl_pipe_gen #(.ALUCTRL_W(ALUCTRL_W), .RESSRC_W(RESSRC_W), .MDU_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .JalrD(JalrD),
        .BranchD(BranchD), .Funct3D(Funct3D), .MulDivD(MulDivD), .ALUSrcAD(ALUSrcAD),
        .ALUSrcBD(ALUSrcBD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .FlushE(FlushE), .ZeroE(ZeroE), .NegE(NegE), .OvfE(OvfE), .CarryE(CarryE),
        .PCSrcE(PCSrcE), .PCJalrE(PCJalrE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .ALUControlE(ALUControlE), .ResultSrcE0(ResultSrcE0), .MduStartE(MduStartE),
        .MduStallE(MduStallE), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
    );

    typedef struct packed {
        logic rw, mw, jump, jalr, branch;
        logic [2:0] f3;
        logic md, asa;
        logic [1:0] asb;
        logic [RESSRC_W-1:0] rs;
        logic [ALUCTRL_W-1:0] ac;
    } op_t;

    op_t me;
    int  hold_left;
    logic mm_rw, mm_mw, mw_rw;
    logic [RESSRC_W-1:0] mm_rs, mw_rs;
    int n_cmp = 0;
    int n_err = 0;
    logic obs_start, obs_stall, obs_rww;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear();
        me = '0; hold_left = 0;
        mm_rw = 1'b0; mm_mw = 1'b0; mm_rs = '0;
        mw_rw = 1'b0; mw_rs = '0;
    endtask

    task automatic model_update();
        op_t d;
        logic stall;
        d = '{RegWriteD, MemWriteD, JumpD, JalrD, BranchD, Funct3D, MulDivD,
              ALUSrcAD, ALUSrcBD, ResultSrcD, ALUControlD};
        stall = me.md && (hold_left > 0);
        mw_rw = mm_rw; mw_rs = mm_rs;
        if (stall) begin
            mm_rw = 1'b0; mm_mw = 1'b0; mm_rs = '0;
        end else begin
            mm_rw = me.rw; mm_mw = me.mw; mm_rs = me.rs;
        end
        if (FlushE) begin
            me = '0; hold_left = 0;
        end else if (stall) begin
            hold_left--;
        end else begin
            me = d; hold_left = d.md ? LAT : 0;
        end
    endtask

    // Inputs were set before the call; check, then advance across one rising edge
    task automatic run_cycle();
        #1;
        if (!reset) model_clear();
        check_eq("PCSrcE", 32'(PCSrcE), 32'(me.jump | (me.branch & taken(me.f3, rs1, rs2))));
        check_eq("PCJalrE", 32'(PCJalrE), 32'(me.jump & me.jalr));
        check_eq("ALUSrcAE", 32'(ALUSrcAE), 32'(me.asa));
        check_eq("ALUSrcBE", 32'(ALUSrcBE), 32'(me.asb));
        check_eq("ALUControlE", 32'(ALUControlE), 32'(me.ac));
        check_eq("ResultSrcE0", 32'(ResultSrcE0), 32'(me.rs[0]));
        check_eq("MduStartE", 32'(MduStartE), 32'(me.md && hold_left == LAT));
        check_eq("MduStallE", 32'(MduStallE), 32'(me.md && hold_left > 0));
        check_eq("MemWriteM", 32'(MemWriteM), 32'(mm_mw));
        check_eq("RegWriteM", 32'(RegWriteM), 32'(mm_rw));
        check_eq("RegWriteW", 32'(RegWriteW), 32'(mw_rw));
        check_eq("ResultSrcW", 32'(ResultSrcW), 32'(mw_rs));
        obs_start = MduStartE; obs_stall = MduStallE; obs_rww = RegWriteW;
        @(posedge clk);
        if (reset) model_update(); else model_clear();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        {RegWriteD, MemWriteD, JumpD, JalrD, BranchD, MulDivD, ALUSrcAD, FlushE} = 8'd0;
        Funct3D = 3'd0; ALUSrcBD = 2'd0; ResultSrcD = '0; ALUControlD = '0;
    endtask

    task automatic random_inputs();
        int kind;
        idle_inputs();
        RegWriteD = 1'($urandom); MemWriteD = 1'($urandom);
        Funct3D = 3'($urandom); ALUSrcAD = 1'($urandom); ALUSrcBD = 2'($urandom);
        ResultSrcD = RESSRC_W'($urandom); ALUControlD = ALUCTRL_W'($urandom);
        kind = int'($urandom_range(0, 5));
        MulDivD = (kind == 0);
        BranchD = (kind == 1) || (kind == 2);
        JumpD   = (kind == 3);
        JalrD   = JumpD & 1'($urandom);
        FlushE  = ($urandom_range(0, 15) == 0);
        rs1 = $urandom;
        case ($urandom_range(0, 3))
            0:       rs2 = rs1;
            1:       rs2 = rs1 ^ 32'h8000_0000;
            default: rs2 = $urandom;
        endcase
    endtask

    task automatic mdu_op(input int flush_at, input int reset_at);
        int t_start, t_w, n_stall;
        t_start = -1; t_w = -1; n_stall = 0;
        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            if (i == 0) begin MulDivD = 1'b1; RegWriteD = 1'b1; ResultSrcD = RESSRC_W'(2); end
            FlushE = (i == flush_at);
            reset  = (i != reset_at);
            run_cycle();
            if (obs_start && t_start < 0) t_start = i;
            if (obs_rww && t_w < 0) t_w = i;
            if (obs_stall) n_stall++;
        end
        reset = 1'b1;
        if (flush_at < 0 && reset_at < 0) begin
            check_eq("mdu_start_to_w", 32'(t_w - t_start), 32'd6);
            check_eq("mdu_stall_cycles", 32'(n_stall), 32'(LAT));
        end else begin
            check_eq("mdu_abort_no_w", 32'(t_w), 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        idle_inputs();
        rs1 = 32'd0; rs2 = 32'd0;
        reset = 1'b0;
        model_clear();
        obs_start = 1'b0; obs_stall = 1'b0; obs_rww = 1'b0;
        @(negedge clk);
        run_cycle();
        run_cycle();
        reset = 1'b1;

        // Branch / jump corner cases from D through E
        idle_inputs(); BranchD = 1'b1; Funct3D = 3'b000; run_cycle();
        idle_inputs(); rs1 = 32'd7; rs2 = 32'd7; run_cycle();
        idle_inputs(); BranchD = 1'b1; Funct3D = 3'b000; run_cycle();
        idle_inputs(); rs1 = 32'd7; rs2 = 32'd8; run_cycle();
        idle_inputs(); BranchD = 1'b1; Funct3D = 3'b100; run_cycle();
        idle_inputs(); rs1 = 32'h7FFF_FFFF; rs2 = 32'hFFFF_FFFF; run_cycle();
        idle_inputs(); BranchD = 1'b1; Funct3D = 3'b111; run_cycle();
        idle_inputs(); rs1 = 32'd9; rs2 = 32'd3; run_cycle();
        idle_inputs(); JumpD = 1'b1; JalrD = 1'b1; run_cycle();
        idle_inputs(); run_cycle();
        idle_inputs(); JumpD = 1'b1; JalrD = 1'b1; FlushE = 1'b1; run_cycle();
        idle_inputs(); run_cycle();

        // MDU: clean op, flush while busy, reset while busy, then back-to-back
        mdu_op(-1, -1);
        mdu_op(2, -1);
        mdu_op(-1, 2);
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            MulDivD = (i == 0) || (i == 5);
            RegWriteD = 1'b1;
            run_cycle();
        end

        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            reset = ($urandom_range(0, 79) != 0);
            run_cycle();
        end
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 8; i++) run_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
